// File: rtl/jb_sysref_pkg.sv
// jb_sysref_pkg: shared types and constants for the PL SYSREF generator.
// Holds the FSM state encoding, the default period derived from the
// 491.52 MHz reference / 3.84 MHz SYSREF ratio, and the default widths.
package jb_sysref_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } sysref_state_t;

    localparam int REFCLK_HZ         = 491_520_000;
    localparam int SYSREF_HZ         = 3_840_000;
    localparam int SYSREF_DEF_PERIOD = REFCLK_HZ / SYSREF_HZ;   // 128

    localparam int SYSREF_PERIOD_W   = 16;
    localparam int SYSREF_CNT_W      = 8;

endpackage

// File: rtl/jb_pl_sysref_gen_if.sv
// jb_pl_sysref_gen_if: configuration, start/stop and status bundle of the
// SYSREF generator. The controller drives the master side; the generator
// is the slave.
interface jb_pl_sysref_gen_if #(
    parameter int PERIOD_W = 16,
    parameter int CNT_W    = 8
) ();
    logic [PERIOD_W-1:0] cfg_period_i;
    logic [CNT_W-1:0]    cfg_pulses_i;
    logic                start_i;
    logic                stop_i;
    logic                busy_o;
    logic                done_o;
    logic [CNT_W-1:0]    pulse_cnt_o;

    modport master (
        output cfg_period_i, cfg_pulses_i, start_i, stop_i,
        input  busy_o, done_o, pulse_cnt_o
    );

    modport slave (
        input  cfg_period_i, cfg_pulses_i, start_i, stop_i,
        output busy_o, done_o, pulse_cnt_o
    );
endinterface

// File: rtl/jb_sysref_phase_cnt.sv
// jb_sysref_phase_cnt: loadable phase counter for the SYSREF period.
// Counts 0..period-1 and wraps. Also reports, for the value the counter
// will hold next cycle, whether it falls in the high half of the period,
// so the SYSREF output flop can be loaded one cycle ahead.
module jb_sysref_phase_cnt #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period,
    output logic [PERIOD_W-1:0] phase,
    output logic                wrap,
    output logic                next_high
);
    logic [PERIOD_W-1:0] phase_q;
    logic [PERIOD_W-1:0] phase_n;

    // next phase value and half-period compare on it
    always_comb begin
        wrap    = (phase_q == (period - 1'b1));
        phase_n = phase_q;
        if (clr) begin
            phase_n = '0;
        end else if (en) begin
            phase_n = wrap ? '0 : phase_q + 1'b1;
        end
        next_high = (phase_n < (period >> 1));
    end

    // phase register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_n;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/jb_pl_sysref_gen.sv
// jb_pl_sysref_gen: JESD204 SYSREF pulse-train generator clocked by
// pl_refclk_i. Continuous, N-pulse burst, or stopped; stop requests drain
// the current period so no runt pulse is produced.
// Optional build macro JB_SYSREF_DIFF_OUT_EN adds the pl_sysref_p/n pins
// driven through an OBUFDS from the sysref_o flop.
//
//  state | meaning
//  IDLE  | waiting for start_i (stop_i blocks acceptance)
//  ARM   | one cycle, phase counter cleared, first pulse preloaded
//  RUN   | emitting pulses, burst terminates after N-th period
//  DRAIN | stop seen, finishing the current period then IDLE
module jb_pl_sysref_gen
    import jb_sysref_pkg::*;
#(
    parameter int PERIOD_W   = SYSREF_PERIOD_W,
    parameter int CNT_W      = SYSREF_CNT_W,
    parameter int DEF_PERIOD = SYSREF_DEF_PERIOD
) (
    input  logic               pl_refclk_i,
    input  logic               pl_rst_i,
    jb_pl_sysref_gen_if.slave  ctrl,
    output logic               sysref_o
`ifdef JB_SYSREF_DIFF_OUT_EN
    ,
    output logic               pl_sysref_p,
    output logic               pl_sysref_n
`endif
);
    sysref_state_t       state_q, state_n;
    logic [PERIOD_W-1:0] period_q;
    logic [CNT_W-1:0]    pulses_q;
    logic [CNT_W-1:0]    pulse_cnt_q;
    logic                accept;
    logic                phase_clr, phase_en;
    logic                done;
    logic                sysref_d;
    logic [PERIOD_W-1:0] phase;
    logic                wrap;
    logic                next_high;
    logic                burst_end;

`ifdef JB_SYSREF_DIFF_OUT_EN
    (* dont_touch = "true", IOB = "TRUE" *) logic sysref_q;
`else
    logic sysref_q;
`endif

    jb_sysref_phase_cnt #(.PERIOD_W(PERIOD_W)) u_phase_cnt (
        .clk       (pl_refclk_i),
        .rst       (pl_rst_i),
        .clr       (phase_clr),
        .en        (phase_en),
        .period    (period_q),
        .phase     (phase),
        .wrap      (wrap),
        .next_high (next_high)
    );

    assign burst_end = wrap && (pulses_q != '0) && (pulse_cnt_q == pulses_q);

    // next-state, counter control and done decode
    always_comb begin
        state_n   = state_q;
        accept    = 1'b0;
        phase_clr = 1'b0;
        phase_en  = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ctrl.start_i && !ctrl.stop_i) begin
                    accept  = 1'b1;
                    state_n = ST_ARM;
                end
            end
            ST_ARM: begin
                phase_clr = 1'b1;
                state_n   = ST_RUN;
            end
            ST_RUN: begin
                phase_en = 1'b1;
                // a stop on the last phase already sits on a period boundary
                if (burst_end || (ctrl.stop_i && wrap)) begin
                    state_n = ST_IDLE;
                    done    = 1'b1;
                end else if (ctrl.stop_i) begin
                    state_n = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                phase_en = 1'b1;
                if (wrap) begin
                    state_n = ST_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        // output flop is loaded from the next state so the first RUN cycle is already high
        sysref_d = ((state_n == ST_RUN) || (state_n == ST_DRAIN)) && next_high;
    end

    // state register
    always_ff @(posedge pl_refclk_i or posedge pl_rst_i) begin
        if (pl_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // configuration latched on accepted start only
    always_ff @(posedge pl_refclk_i or posedge pl_rst_i) begin
        if (pl_rst_i) begin
            period_q <= '0;
            pulses_q <= '0;
        end else if (accept) begin
            period_q <= (ctrl.cfg_period_i < PERIOD_W'(2)) ? PERIOD_W'(DEF_PERIOD)
                                                           : ctrl.cfg_period_i;
            pulses_q <= ctrl.cfg_pulses_i;
        end
    end

    // burst pulse counter, bumps at each period start and saturates
    always_ff @(posedge pl_refclk_i or posedge pl_rst_i) begin
        if (pl_rst_i) begin
            pulse_cnt_q <= '0;
        end else if (accept) begin
            pulse_cnt_q <= '0;
        end else if (((state_q == ST_RUN) || (state_q == ST_DRAIN)) && (phase == '0)
                     && (pulse_cnt_q != '1)) begin
            pulse_cnt_q <= pulse_cnt_q + 1'b1;
        end
    end

    // SYSREF output flop, the only source for the pins
    always_ff @(posedge pl_refclk_i or posedge pl_rst_i) begin
        if (pl_rst_i) begin
            sysref_q <= 1'b0;
        end else begin
            sysref_q <= sysref_d;
        end
    end

    assign sysref_o         = sysref_q;
    assign ctrl.busy_o      = (state_q != ST_IDLE);
    assign ctrl.done_o      = done;
    assign ctrl.pulse_cnt_o = pulse_cnt_q;

`ifdef JB_SYSREF_DIFF_OUT_EN
    OBUFDS u_sysref_obufds (
        .O  (pl_sysref_p),
        .OB (pl_sysref_n),
        .I  (sysref_q)
    );
`endif

endmodule

// File: tb/tb_jb_pl_sysref_gen.sv
// tb_jb_pl_sysref_gen: directed bench for the PL SYSREF generator.
// Cycle c=1 is the first cycle after the edge that accepts start_i.
`timescale 1ns/1ps
module tb_jb_pl_sysref_gen;

    logic clk = 1'b0;
    logic rst;
    logic sysref;
`ifdef JB_SYSREF_DIFF_OUT_EN
    logic sysref_p, sysref_n;
`endif
    int diff_err = 0;
    int n_checks = 0;
    int n_fail   = 0;

    jb_pl_sysref_gen_if #(.PERIOD_W(16), .CNT_W(8)) ctrl ();

    jb_pl_sysref_gen dut (
        .pl_refclk_i (clk),
        .pl_rst_i    (rst),
        .ctrl        (ctrl),
        .sysref_o    (sysref)
`ifdef JB_SYSREF_DIFF_OUT_EN
        ,
        .pl_sysref_p (sysref_p),
        .pl_sysref_n (sysref_n)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        int p; int n;
        int inj; int inj_pulse; int inj_phase;   // inj: 0 none, 1 stop, 2 start
        int rise; int hi; int per; int done_at; int cnt;
    } vec_t;

    vec_t vecs[8];

    task automatic start_burst(input int p, input int n);
        @(negedge clk);
        ctrl.cfg_period_i = 16'(p);
        ctrl.cfg_pulses_i = 8'(n);
        ctrl.start_i      = 1'b1;
        @(posedge clk);
        #1 ctrl.start_i   = 1'b0;
    endtask

    task automatic observe(input int max_cyc, input int inj, input int inj_pulse, input int inj_phase,
                           output int busy1, output int sys1, output int first_rise, output int n_rise,
                           output int hi_min, output int hi_max, output int per_min, output int per_max,
                           output int done_at, output int cnt_at_done);
        int  hi_len, last_rise, n_hi, n_per;
        logic prev;
        busy1 = 0; sys1 = 0; first_rise = -1; n_rise = 0;
        hi_min = 0; hi_max = 0; per_min = 0; per_max = 0;
        done_at = -1; cnt_at_done = -1;
        hi_len = 0; last_rise = -1; n_hi = 0; n_per = 0; prev = 1'b0;
        for (int c = 1; c <= max_cyc && done_at < 0; c++) begin
            @(negedge clk);
            ctrl.stop_i  = 1'b0;
            ctrl.start_i = 1'b0;
`ifdef JB_SYSREF_DIFF_OUT_EN
            if ((sysref_p !== sysref) || (sysref_n !== ~sysref)) diff_err++;
`endif
            if (c == 1) begin
                busy1 = int'(ctrl.busy_o);
                sys1  = int'(sysref);
            end
            if (sysref && !prev) begin
                n_rise++;
                if (first_rise < 0) first_rise = c;
                if (last_rise >= 0) begin
                    if (n_per == 0 || c - last_rise < per_min) per_min = c - last_rise;
                    if (n_per == 0 || c - last_rise > per_max) per_max = c - last_rise;
                    n_per++;
                end
                last_rise = c;
                hi_len = 0;
            end
            if (sysref) hi_len++;
            if (!sysref && prev) begin
                if (n_hi == 0 || hi_len < hi_min) hi_min = hi_len;
                if (n_hi == 0 || hi_len > hi_max) hi_max = hi_len;
                n_hi++;
            end
            if (inj != 0 && n_rise == inj_pulse && last_rise >= 0 && c - last_rise == inj_phase) begin
                if (inj == 1) begin
                    ctrl.stop_i = 1'b1;
                end else begin
                    ctrl.start_i      = 1'b1;
                    ctrl.cfg_period_i = 16'd7;
                    ctrl.cfg_pulses_i = 8'd9;
                end
            end
            if (ctrl.done_o) begin
                done_at     = c;
                cnt_at_done = int'(ctrl.pulse_cnt_o);
            end
            prev = sysref;
        end
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        ctrl.stop_i = 1'b1;
        while (ctrl.busy_o && k < 1000) begin
            @(negedge clk);
            k++;
        end
        ctrl.stop_i = 1'b0;
        check_val({tag, "_idle_timeout"}, 32'(ctrl.busy_o), 32'd0);
    endtask

    task automatic run_vec(input int i);
        int busy1, sys1, first_rise, n_rise, hi_min, hi_max, per_min, per_max, done_at, cnt_at_done;
        string t;
        t = $sformatf("v%0d", i);
        start_burst(vecs[i].p, vecs[i].n);
        observe(vecs[i].done_at + 100, vecs[i].inj, vecs[i].inj_pulse, vecs[i].inj_phase,
                busy1, sys1, first_rise, n_rise, hi_min, hi_max, per_min, per_max, done_at, cnt_at_done);
        check_val({t, "_busy_c1"},    32'(busy1),       32'd1);
        check_val({t, "_sysref_c1"},  32'(sys1),        32'd0);
        check_val({t, "_first_rise"}, 32'(first_rise),  32'd2);
        check_val({t, "_pulses"},     32'(n_rise),      32'(vecs[i].rise));
        check_val({t, "_hi_min"},     32'(hi_min),      32'(vecs[i].hi));
        check_val({t, "_hi_max"},     32'(hi_max),      32'(vecs[i].hi));
        check_val({t, "_per_min"},    32'(per_min),     32'(vecs[i].per));
        check_val({t, "_per_max"},    32'(per_max),     32'(vecs[i].per));
        check_val({t, "_done_at"},    32'(done_at),     32'(vecs[i].done_at));
        check_val({t, "_cnt_done"},   32'(cnt_at_done), 32'(vecs[i].cnt));
        @(negedge clk);
        check_val({t, "_busy_after"}, 32'(ctrl.busy_o),      32'd0);
        check_val({t, "_done_after"}, 32'(ctrl.done_o),      32'd0);
        check_val({t, "_cnt_after"},  32'(ctrl.pulse_cnt_o), 32'(vecs[i].cnt));
        wait_idle(t);
    endtask

    initial begin
        logic [7:0] sys_vec, done_vec, busy_vec;

        //          p    n   inj pls ph  rise hi  per  done cnt
        vecs[0] = '{128, 4,  0,  0,  0,  4,   64, 128, 513, 4};
        vecs[1] = '{128, 0,  1,  3,  10, 3,   64, 128, 385, 3};
        vecs[2] = '{1,   2,  0,  0,  0,  2,   64, 128, 257, 2};
        vecs[3] = '{5,   1,  0,  0,  0,  1,   2,  0,   6,   1};
        vecs[4] = '{5,   3,  0,  0,  0,  3,   2,  5,   16,  3};
        vecs[5] = '{7,   2,  0,  0,  0,  2,   3,  7,   15,  2};
        vecs[6] = '{16,  3,  2,  2,  3,  3,   8,  16,  49,  3};
        vecs[7] = '{2,   3,  0,  0,  0,  3,   1,  2,   7,   3};

        rst = 1'b1;
        ctrl.start_i = 1'b0;
        ctrl.stop_i  = 1'b0;
        ctrl.cfg_period_i = '0;
        ctrl.cfg_pulses_i = '0;
        repeat (3) @(negedge clk);
        check_val("rst_sysref", 32'(sysref),           32'd0);
        check_val("rst_busy",   32'(ctrl.busy_o),      32'd0);
        check_val("rst_done",   32'(ctrl.done_o),      32'd0);
        check_val("rst_cnt",    32'(ctrl.pulse_cnt_o), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(i);
        check_val("diff_pins", 32'(diff_err), 32'd0);

        // start and stop together in IDLE: nothing happens
        @(negedge clk);
        ctrl.cfg_period_i = 16'd8;
        ctrl.cfg_pulses_i = 8'd1;
        ctrl.start_i = 1'b1;
        ctrl.stop_i  = 1'b1;
        repeat (4) @(negedge clk);
        check_val("startstop_busy",   32'(ctrl.busy_o), 32'd0);
        check_val("startstop_sysref", 32'(sysref),      32'd0);
        ctrl.start_i = 1'b0;
        ctrl.stop_i  = 1'b0;

        // start held high: P=4, N=1 bursts back to back
        @(negedge clk);
        ctrl.cfg_period_i = 16'd4;
        ctrl.cfg_pulses_i = 8'd1;
        ctrl.start_i = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            sys_vec[c-1]  = sysref;
            done_vec[c-1] = ctrl.done_o;
            busy_vec[c-1] = ctrl.busy_o;
        end
        check_val("b2b_sysref", 32'(sys_vec),  32'h86);
        check_val("b2b_done",   32'(done_vec), 32'h10);
        check_val("b2b_busy",   32'(busy_vec), 32'hDF);
        ctrl.start_i = 1'b0;
        wait_idle("b2b");

        // asynchronous reset in the middle of a high phase
        start_burst(128, 4);
        repeat (20) @(negedge clk);
        check_val("pre_rst_sysref", 32'(sysref),           32'd1);
        check_val("pre_rst_cnt",    32'(ctrl.pulse_cnt_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_val("async_rst_sysref", 32'(sysref),           32'd0);
        check_val("async_rst_busy",   32'(ctrl.busy_o),      32'd0);
        check_val("async_rst_cnt",    32'(ctrl.pulse_cnt_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_vec(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
